// File: rtl/inst_align_queue.sv
// Fetch-word realigner and RV32IC instruction queue feeding the decoder.
// Optional RVC_EXPAND_EN: expand compressed halves to RV32I; otherwise they pass zero-extended.
module inst_align_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        wrong_predicted,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  input  logic [31:0] fetch_data,
  output logic        fetch_ready,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        out_is_c,
  input  logic        out_ready
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        is_c;
  } entry_t;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;

  function automatic logic [31:0] expand(input logic [15:0] h);
`ifdef RVC_EXPAND_EN
    logic [31:0] r;
    logic [4:0]  rd, rs2, rdp, rsp;
    logic [11:0] imm6, lw_imm, sp_imm;
    logic [20:0] jimm;
    logic [12:0] bimm;
    r      = '0;
    rd     = h[11:7];
    rs2    = h[6:2];
    rdp    = {2'b01, h[4:2]};
    rsp    = {2'b01, h[9:7]};
    imm6   = {{6{h[12]}}, h[12], h[6:2]};
    lw_imm = {5'b0, h[5], h[12:10], h[6], 2'b00};
    sp_imm = {{2{h[12]}}, h[12], h[4:3], h[5], h[2], h[6], 4'b0};
    jimm   = {{9{h[12]}}, h[12], h[8], h[10:9], h[6], h[7], h[2], h[11], h[5:3], 1'b0};
    bimm   = {{4{h[12]}}, h[12], h[6:5], h[2], h[11:10], h[4:3], 1'b0};
    case ({h[1:0], h[15:13]})
      5'b00_000: if (h[12:5] != 8'd0)
                   r = {2'b0, h[10:7], h[12:11], h[5], h[6], 2'b00, 5'd2, 3'b000, rdp, OP_IMM};
      5'b00_010: r = {lw_imm, rsp, 3'b010, rdp, 7'b0000011};
      5'b00_110: r = {lw_imm[11:5], rdp, rsp, 3'b010, lw_imm[4:0], 7'b0100011};
      5'b01_000: r = {imm6, rd, 3'b000, rd, OP_IMM};
      5'b01_001: r = {jimm[20], jimm[10:1], jimm[11], jimm[19:12], 5'd1, 7'b1101111};
      5'b01_010: r = {imm6, 5'd0, 3'b000, rd, OP_IMM};
      5'b01_011: begin
        if (rd == 5'd2) begin
          if ({h[12], h[6:2]} != 6'd0) r = {sp_imm, 5'd2, 3'b000, 5'd2, OP_IMM};
        end else if ({h[12], h[6:2]} != 6'd0) begin
          r = {{14{h[12]}}, h[12], h[6:2], rd, 7'b0110111};
        end
      end
      5'b01_100: begin
        case (h[11:10])
          2'b00: if (!h[12]) r = {7'b0000000, h[6:2], rsp, 3'b101, rsp, OP_IMM};
          2'b01: if (!h[12]) r = {7'b0100000, h[6:2], rsp, 3'b101, rsp, OP_IMM};
          2'b10: r = {imm6, rsp, 3'b111, rsp, OP_IMM};
          default: begin
            if (!h[12]) begin
              case (h[6:5])
                2'b00:   r = {7'b0100000, rdp, rsp, 3'b000, rsp, OP_REG};
                2'b01:   r = {7'b0000000, rdp, rsp, 3'b100, rsp, OP_REG};
                2'b10:   r = {7'b0000000, rdp, rsp, 3'b110, rsp, OP_REG};
                default: r = {7'b0000000, rdp, rsp, 3'b111, rsp, OP_REG};
              endcase
            end
          end
        endcase
      end
      5'b01_101: r = {jimm[20], jimm[10:1], jimm[11], jimm[19:12], 5'd0, 7'b1101111};
      5'b01_110: r = {bimm[12], bimm[10:5], 5'd0, rsp, 3'b000, bimm[4:1], bimm[11], 7'b1100011};
      5'b01_111: r = {bimm[12], bimm[10:5], 5'd0, rsp, 3'b001, bimm[4:1], bimm[11], 7'b1100011};
      5'b10_000: if (!h[12]) r = {7'b0000000, h[6:2], rd, 3'b001, rd, OP_IMM};
      5'b10_010: if (rd != 5'd0)
                   r = {4'b0, h[3:2], h[12], h[6:4], 2'b00, 5'd2, 3'b010, rd, 7'b0000011};
      5'b10_100: begin
        if (!h[12]) begin
          if (rs2 == 5'd0) begin
            if (rd != 5'd0) r = {12'b0, rd, 3'b000, 5'd0, 7'b1100111};
          end else begin
            r = {7'b0, rs2, 5'd0, 3'b000, rd, OP_REG};
          end
        end else begin
          if (rs2 == 5'd0) begin
            if (rd == 5'd0) r = 32'h0010_0073;
            else            r = {12'b0, rd, 3'b000, 5'd1, 7'b1100111};
          end else begin
            r = {7'b0, rs2, rd, 3'b000, rd, OP_REG};
          end
        end
      end
      5'b10_110: r = {4'b0, h[8:7], h[12], rs2, 5'd2, 3'b010, h[11:9], 2'b00, 7'b0100011};
      default:   r = '0;
    endcase
    return r;
`else
    return {16'b0, h};
`endif
  endfunction

  entry_t           ram [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, wr_ptr1, nxt_rd;
  logic [PTR_W:0]   count, nxt_cnt;
  logic             hold_vld;
  logic [15:0]      hold_half;
  logic [31:0]      hold_addr;

  logic        accept, pop;
  logic        hold_hit, do_hi, lo_push, hi_push, hold_take;
  logic [1:0]  n_push;
  logic [31:0] hi_addr;
  entry_t      lo_e, hi_e, e0, e1, head;

  assign fetch_ready = !rst_in && !wrong_predicted && (count <= (PTR_W+1)'(DEPTH-2));
  assign accept      = fetch_valid && fetch_ready && rdy_in;
  assign pop         = out_valid && out_ready && rdy_in;
  assign wr_ptr1     = wr_ptr + PTR_W'(1);

  // Low half first (unless the word is entered mid-way), then the high half.
  always_comb begin
    hold_hit  = hold_vld && !fetch_addr[1] && (fetch_addr == hold_addr + 32'd2);
    hi_addr   = {fetch_addr[31:2], 2'b10};
    lo_push   = 1'b0;
    do_hi     = 1'b0;
    lo_e      = '0;
    if (fetch_addr[1]) begin
      do_hi = 1'b1;
    end else if (hold_hit) begin
      lo_push = 1'b1;
      lo_e    = '{inst: {fetch_data[15:0], hold_half}, addr: hold_addr, is_c: 1'b0};
      do_hi   = 1'b1;
    end else if (fetch_data[1:0] == 2'b11) begin
      lo_push = 1'b1;
      lo_e    = '{inst: fetch_data, addr: fetch_addr, is_c: 1'b0};
    end else begin
      lo_push = 1'b1;
      lo_e    = '{inst: expand(fetch_data[15:0]), addr: fetch_addr, is_c: 1'b1};
      do_hi   = 1'b1;
    end
    hi_push   = do_hi && (fetch_data[17:16] != 2'b11);
    hold_take = do_hi && (fetch_data[17:16] == 2'b11);
    hi_e      = '{inst: expand(fetch_data[31:16]), addr: hi_addr, is_c: 1'b1};
    e0        = lo_push ? lo_e : hi_e;
    e1        = hi_e;
    n_push    = {1'b0, lo_push} + {1'b0, hi_push};
  end

  // Head register looks ahead to the post-edge head, bypassing entries written this cycle.
  always_comb begin
    nxt_rd  = rd_ptr + PTR_W'(pop);
    nxt_cnt = count + (PTR_W+1)'(accept ? n_push : 2'd0) - (PTR_W+1)'(pop);
    if (accept && (n_push != 2'd0) && (nxt_rd == wr_ptr))
      head = e0;
    else if (accept && (n_push == 2'd2) && (nxt_rd == wr_ptr1))
      head = e1;
    else
      head = ram[nxt_rd];
  end

  always_ff @(posedge clk_in) begin
    if (accept) begin
      if (n_push != 2'd0) ram[wr_ptr]  <= e0;
      if (n_push == 2'd2) ram[wr_ptr1] <= e1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      hold_vld  <= 1'b0;
      hold_half <= '0;
      hold_addr <= '0;
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_addr  <= '0;
      out_is_c  <= 1'b0;
    end else if (rdy_in) begin
      if (wrong_predicted) begin
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        count     <= '0;
        hold_vld  <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        rd_ptr    <= nxt_rd;
        count     <= nxt_cnt;
        out_valid <= (nxt_cnt != '0);
        if (nxt_cnt != '0) begin
          out_inst <= head.inst;
          out_addr <= head.addr;
          out_is_c <= head.is_c;
        end
        if (accept) begin
          wr_ptr   <= wr_ptr + PTR_W'(n_push);
          hold_vld <= hold_take;
          if (hold_take) begin
            hold_half <= fetch_data[31:16];
            hold_addr <= hi_addr;
          end
        end
      end
    end
  end

endmodule
